// File: rtl/syncram_dual_be_if.sv
// Port bundle for one side of the byte-enable dual-port RAM.
// The master drives the request signals and the slave (RAM) returns the read data and the status strobes.
interface syncram_dual_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int AW         = 11,
    parameter int NB         = 4
);
    logic [AW-1:0]         addr;
    logic [DATA_WIDTH-1:0] datain;
    logic [NB-1:0]         be;
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] dataout;
    logic                  valid;
    logic                  err;

    modport master (output addr, datain, be, we, re, input dataout, valid, err);
    modport slave  (input addr, datain, be, we, re, output dataout, valid, err);
endinterface

// File: rtl/syncram_dual_be.sv
// True dual-port synchronous RAM with per-byte write enables and selectable read-during-write.
// It also has an optional output register, out-of-range detection, and a clear sweep that runs after reset.
module syncram_dual_be #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    DATA_COUNT     = 1536,
    parameter int                    BYTE_WIDTH     = 8,
    parameter int                    RDW_MODE       = 0,
    parameter int                    OUT_REG        = 0,
    parameter int                    CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE     = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy,
    syncram_dual_be_if.slave  port_a,
    syncram_dual_be_if.slave  port_b
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;
    localparam int AW = $clog2(DATA_COUNT);
    localparam logic [AW:0]   LP_COUNT = (AW+1)'(DATA_COUNT);
    localparam logic [AW-1:0] LP_LAST  = AW'(DATA_COUNT - 1);

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t                r_state, w_next_state;
    logic [AW-1:0]         r_clr_cnt;
    logic                  w_sweep_we;
    logic [DATA_WIDTH-1:0] r_mem [DATA_COUNT];

    // Index 0 is port A, index 1 is port B.
    logic [AW-1:0]         w_addr [2];
    logic [DATA_WIDTH-1:0] w_din [2];
    logic [NB-1:0]         w_be [2];
    logic                  w_we [2], w_re [2];
    logic                  w_req [2], w_in_range [2], w_wr [2], w_rd [2], w_oor [2];
    logic [DATA_WIDTH-1:0] w_mask [2], w_old [2], w_rd_word [2];
    logic [DATA_WIDTH-1:0] r_s1_data [2], w_dout [2];
    logic                  r_s1_valid [2], r_s1_err [2], w_valid [2], w_err [2];

    assign w_addr[0] = port_a.addr;   assign w_addr[1] = port_b.addr;
    assign w_din[0]  = port_a.datain; assign w_din[1]  = port_b.datain;
    assign w_be[0]   = port_a.be;     assign w_be[1]   = port_b.be;
    assign w_we[0]   = port_a.we;     assign w_we[1]   = port_b.we;
    assign w_re[0]   = port_a.re;     assign w_re[1]   = port_b.re;
    assign port_a.dataout = w_dout[0];  assign port_b.dataout = w_dout[1];
    assign port_a.valid   = w_valid[0]; assign port_b.valid   = w_valid[1];
    assign port_a.err     = w_err[0];   assign port_b.err     = w_err[1];

    always_ff @(posedge clk) begin
        if (reset) r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state == ST_CLEAR && r_clr_cnt == LP_LAST) w_next_state = ST_IDLE;
    end

    always_comb begin
        busy       = (r_state == ST_CLEAR);
        w_sweep_we = busy && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset)           r_clr_cnt <= '0;
        else if (w_sweep_we) r_clr_cnt <= (r_clr_cnt == LP_LAST) ? '0 : r_clr_cnt + 1'b1;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_mask[p]     = '0;
            w_in_range[p] = ({1'b0, w_addr[p]} < LP_COUNT);
            w_req[p]      = !busy && !reset && (w_we[p] || w_re[p]);
            w_wr[p]       = w_req[p] && w_in_range[p] && w_we[p];
            w_rd[p]       = w_req[p] && w_in_range[p] && w_re[p];
            w_oor[p]      = w_req[p] && !w_in_range[p];
            for (int l = 0; l < NB; l++)
                w_mask[p][l*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{w_be[p][l]}};
            w_old[p]      = r_mem[w_addr[p]];
            // The merge uses only this port's own lanes; a cross-port read always sees the old word.
            w_rd_word[p]  = (RDW_MODE != 0 && w_we[p])
                          ? ((w_old[p] & ~w_mask[p]) | (w_din[p] & w_mask[p])) : w_old[p];
        end
    end

    // NOTE: the memory array has no reset; the clear sweep makes its contents deterministic.
    // Port B is applied first so that port A's lanes take priority on a same-address collision.
    always_ff @(posedge clk) begin
        if (w_sweep_we) begin
            r_mem[r_clr_cnt] <= INIT_VALUE;
        end else begin
            for (int p = 1; p >= 0; p--)
                if (w_wr[p])
                    for (int l = 0; l < NB; l++)
                        if (w_be[p][l])
                            r_mem[w_addr[p]][l*BYTE_WIDTH +: BYTE_WIDTH] <= w_din[p][l*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                r_s1_valid[p] <= 1'b0;
                r_s1_err[p]   <= 1'b0;
                r_s1_data[p]  <= '0;
            end else begin
                r_s1_valid[p] <= w_rd[p];
                r_s1_err[p]   <= w_oor[p];
                if (w_rd[p]) r_s1_data[p] <= w_rd_word[p];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [DATA_WIDTH-1:0] r_s2_data [2];
        logic                  r_s2_valid [2], r_s2_err [2];

        always_ff @(posedge clk) begin
            for (int p = 0; p < 2; p++) begin
                if (reset) begin
                    r_s2_valid[p] <= 1'b0;
                    r_s2_err[p]   <= 1'b0;
                    r_s2_data[p]  <= '0;
                end else begin
                    r_s2_valid[p] <= r_s1_valid[p];
                    r_s2_err[p]   <= r_s1_err[p];
                    if (r_s1_valid[p]) r_s2_data[p] <= r_s1_data[p];
                end
            end
        end

        always_comb begin
            for (int p = 0; p < 2; p++) begin
                w_dout[p]  = r_s2_data[p];
                w_valid[p] = r_s2_valid[p];
                w_err[p]   = r_s2_err[p];
            end
        end
    end else begin : g_no_reg
        always_comb begin
            for (int p = 0; p < 2; p++) begin
                w_dout[p]  = r_s1_data[p];
                w_valid[p] = r_s1_valid[p];
                w_err[p]   = r_s1_err[p];
            end
        end
    end
endmodule

// File: tb/tb_syncram_dual_be.sv
// Bench for syncram_dual_be: two instances share one stimulus stream, one with (RDW old, no out reg)
// and one with (RDW merged, out reg), and both are checked every cycle against a word-array model.
module tb_syncram_dual_be;
    localparam int N = 1536;
    localparam logic [31:0] INIT = 32'hDEADBEEF;

    typedef struct packed { logic v; logic e; logic [31:0] d; } ev_t;

    logic clk, rst;
    logic [10:0] t_addr [2];
    logic [31:0] t_din [2];
    logic [3:0]  t_be [2];
    logic        t_we [2], t_re [2];

    logic [31:0] o_dout [2][2];
    logic        o_valid [2][2], o_err [2][2], o_busy [2];

    int n_tests = 0, n_fail = 0;
    logic chk_en = 1'b0;

    // Model state: word array, clear progress, one delay stage for the registered-output instance.
    logic [31:0] m_mem [N];
    int          m_clear_left = 0, m_clear_idx = 0;
    ev_t         m_pres [2][2], m_stage [2];
    logic [31:0] m_dout [2][2];

    syncram_dual_be_if #(.DATA_WIDTH(32), .AW(11), .NB(4)) if0a(), if0b(), if1a(), if1b();

    assign if0a.addr = t_addr[0]; assign if0a.datain = t_din[0]; assign if0a.be = t_be[0];
    assign if0a.we = t_we[0]; assign if0a.re = t_re[0];
    assign if0b.addr = t_addr[1]; assign if0b.datain = t_din[1]; assign if0b.be = t_be[1];
    assign if0b.we = t_we[1]; assign if0b.re = t_re[1];
    assign if1a.addr = t_addr[0]; assign if1a.datain = t_din[0]; assign if1a.be = t_be[0];
    assign if1a.we = t_we[0]; assign if1a.re = t_re[0];
    assign if1b.addr = t_addr[1]; assign if1b.datain = t_din[1]; assign if1b.be = t_be[1];
    assign if1b.we = t_we[1]; assign if1b.re = t_re[1];

    assign o_dout[0][0] = if0a.dataout; assign o_valid[0][0] = if0a.valid; assign o_err[0][0] = if0a.err;
    assign o_dout[0][1] = if0b.dataout; assign o_valid[0][1] = if0b.valid; assign o_err[0][1] = if0b.err;
    assign o_dout[1][0] = if1a.dataout; assign o_valid[1][0] = if1a.valid; assign o_err[1][0] = if1a.err;
    assign o_dout[1][1] = if1b.dataout; assign o_valid[1][1] = if1b.valid; assign o_err[1][1] = if1b.err;

    syncram_dual_be #(.DATA_WIDTH(32), .DATA_COUNT(N), .BYTE_WIDTH(8), .RDW_MODE(0), .OUT_REG(0),
                      .CLEAR_ON_RESET(1), .INIT_VALUE(INIT))
        dut0 (.clk(clk), .reset(rst), .busy(o_busy[0]), .port_a(if0a), .port_b(if0b));

    syncram_dual_be #(.DATA_WIDTH(32), .DATA_COUNT(N), .BYTE_WIDTH(8), .RDW_MODE(1), .OUT_REG(1),
                      .CLEAR_ON_RESET(1), .INIT_VALUE(INIT))
        dut1 (.clk(clk), .reset(rst), .busy(o_busy[1]), .port_a(if1a), .port_b(if1b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Applies the RAM rules to the inputs present at this rising edge.
    task automatic model_edge();
        ev_t ev [2][2];
        logic [31:0] old, mask, merged;
        if (rst) begin
            m_clear_left = N;
            m_clear_idx  = 0;
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++) begin
                    m_pres[d][p] = '0;
                    m_dout[d][p] = '0;
                end
            m_stage[0] = '0;
            m_stage[1] = '0;
            return;
        end
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++) ev[d][p] = '0;
        if (m_clear_left > 0) begin
            m_mem[m_clear_idx] = INIT;
            m_clear_idx++;
            m_clear_left--;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!(t_we[p] || t_re[p])) continue;
                if (int'(t_addr[p]) >= N) begin
                    ev[0][p].e = 1'b1;
                    ev[1][p].e = 1'b1;
                end else if (t_re[p]) begin
                    old = m_mem[t_addr[p]];
                    mask = {{8{t_be[p][3]}}, {8{t_be[p][2]}}, {8{t_be[p][1]}}, {8{t_be[p][0]}}};
                    merged = (old & ~mask) | (t_din[p] & mask);
                    ev[0][p] = '{v: 1'b1, e: 1'b0, d: old};
                    ev[1][p] = '{v: 1'b1, e: 1'b0, d: t_we[p] ? merged : old};
                end
            end
            for (int p = 1; p >= 0; p--)
                if (t_we[p] && int'(t_addr[p]) < N)
                    for (int l = 0; l < 4; l++)
                        if (t_be[p][l]) m_mem[t_addr[p]][l*8 +: 8] = t_din[p][l*8 +: 8];
        end
        for (int p = 0; p < 2; p++) begin
            m_pres[0][p] = ev[0][p];
            m_pres[1][p] = m_stage[p];
            m_stage[p]   = ev[1][p];
        end
        for (int d = 0; d < 2; d++)
            for (int p = 0; p < 2; p++)
                if (m_pres[d][p].v) m_dout[d][p] = m_pres[d][p].d;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("cmp dut%0d busy", d), 32'(o_busy[d]), 32'(m_clear_left > 0));
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("cmp dut%0d p%0d dout", d, p), o_dout[d][p], m_dout[d][p]);
                    check($sformatf("cmp dut%0d p%0d valid", d, p), 32'(o_valid[d][p]), 32'(m_pres[d][p].v));
                    check($sformatf("cmp dut%0d p%0d err", d, p), 32'(o_err[d][p]), 32'(m_pres[d][p].e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic we, input logic re, input int addr,
                            input logic [31:0] din, input logic [3:0] be);
        t_we[p] = we; t_re[p] = re; t_addr[p] = addr[10:0]; t_din[p] = din; t_be[p] = be;
    endtask

    task automatic clr_ports();
        for (int p = 0; p < 2; p++) set_port(p, 1'b0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    // Read on one port, then check the unregistered and the registered instance at their latencies.
    task automatic rd_lit(input int p, input int addr, input logic [31:0] exp0, input logic [31:0] exp1);
        set_port(p, 1'b0, 1'b1, addr, 32'h0, 4'h0);
        tick();
        clr_ports();
        check($sformatf("lit d0 p%0d valid @%0d", p, addr), 32'(o_valid[0][p]), 32'd1);
        check($sformatf("lit d0 p%0d dout @%0d", p, addr), o_dout[0][p], exp0);
        tick();
        check($sformatf("lit d1 p%0d valid @%0d", p, addr), 32'(o_valid[1][p]), 32'd1);
        check($sformatf("lit d1 p%0d dout @%0d", p, addr), o_dout[1][p], exp1);
    endtask

    task automatic count_busy(input string name);
        int cnt = 0;
        while (o_busy[0] && cnt < 3000) begin
            cnt++;
            tick();
        end
        check(name, 32'(cnt), 32'(N));
    endtask

    initial begin
        rst = 1'b1;
        clr_ports();
        repeat (3) tick();
        chk_en = 1'b1;
        check("reset dout d0a", o_dout[0][0], 32'h0);
        check("reset busy d1", 32'(o_busy[1]), 32'd1);
        rst = 1'b0;
        count_busy("busy cycles after reset");

        rd_lit(0, 0, INIT, INIT);
        rd_lit(1, 767, INIT, INIT);
        rd_lit(0, 1535, INIT, INIT);

        set_port(0, 1'b1, 1'b0, 5, 32'h11223344, 4'b1111); tick();
        set_port(0, 1'b1, 1'b0, 5, 32'hAABBCCDD, 4'b0101); tick();
        clr_ports();
        rd_lit(0, 5, 32'h11BB33DD, 32'h11BB33DD);

        set_port(0, 1'b1, 1'b0, 9, 32'h0, 4'b1111); tick();
        set_port(0, 1'b1, 1'b1, 9, 32'h5A5A5A5A, 4'b1111);
        set_port(1, 1'b0, 1'b1, 9, 32'h0, 4'b0000);
        tick();
        clr_ports();
        check("rdw d0 same-port", o_dout[0][0], 32'h0);
        check("rdw d0 cross-port", o_dout[0][1], 32'h0);
        tick();
        check("rdw d1 same-port", o_dout[1][0], 32'h5A5A5A5A);
        check("rdw d1 cross-port", o_dout[1][1], 32'h0);

        set_port(0, 1'b1, 1'b0, 20, 32'hAAAAAAAA, 4'b0011);
        set_port(1, 1'b1, 1'b0, 20, 32'hBBBBBBBB, 4'b1111);
        tick();
        clr_ports();
        rd_lit(1, 20, 32'hBBBBAAAA, 32'hBBBBAAAA);

        rd_lit(0, 0, INIT, INIT);
        set_port(0, 1'b0, 1'b1, 1536, 32'h0, 4'h0);
        set_port(1, 1'b1, 1'b0, 2047, 32'hFFFFFFFF, 4'hF);
        tick();
        clr_ports();
        check("oor d0 err a", 32'(o_err[0][0]), 32'd1);
        check("oor d0 err b", 32'(o_err[0][1]), 32'd1);
        check("oor d0 valid a", 32'(o_valid[0][0]), 32'd0);
        check("oor d0 dout hold", o_dout[0][0], INIT);
        tick();
        check("oor d1 err a", 32'(o_err[1][0]), 32'd1);
        check("oor d1 valid a", 32'(o_valid[1][0]), 32'd0);
        check("oor d1 dout hold", o_dout[1][0], INIT);
        rd_lit(0, 0, INIT, INIT);

        for (int c = 0; c < 2500; c++) begin
            for (int p = 0; p < 2; p++) begin
                int a;
                a = ($urandom % 10 == 0) ? int'($urandom_range(1530, 2047)) : int'($urandom_range(0, 15));
                set_port(p, ($urandom % 3) == 0, ($urandom % 2) == 1, a, $urandom, 4'($urandom));
            end
            tick();
        end
        clr_ports();
        tick();

        set_port(0, 1'b0, 1'b1, 3, 32'h0, 4'h0);
        tick();
        clr_ports();
        rst = 1'b1;
        tick();
        check("reset drops d1 read", 32'(o_valid[1][0]), 32'd0);
        rst = 1'b0;
        repeat (700) tick();
        check("mid-sweep busy", 32'(o_busy[0]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_busy("busy cycles after mid-sweep reset");
        rd_lit(1, 1000, INIT, INIT);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
